// File: rtl/cook_sequencer.sv
// Microwave cook controller: IDLE/COOK/PAUSE/DONE sequencing and LED controls.
// Optional COOK_ADD30_EN: start_btn while cooking adds 30 s (saturating).
module cook_sequencer #(
  parameter int TIME_W     = 8,
  parameter int BEEP_TICKS = 3
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start_btn,
  input  logic              stop_btn,
  input  logic              door_open,
  input  logic [1:0]        mode_sel,
  input  logic [TIME_W-1:0] time_load,
  output logic              led_en,
  output logic              led_start,
  output logic              led_idle,
  output logic [1:0]        led_mode,
  output logic [TIME_W-1:0] time_left,
  output logic              done_beep,
  output logic [1:0]        state
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] COOK  = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  localparam int BW = (BEEP_TICKS < 1) ? 1 : $clog2(BEEP_TICKS + 1);
  localparam logic [BW-1:0] BEEP_LD = BW'(BEEP_TICKS);

  logic [BW-1:0]     beep_cnt;
  logic [BW-1:0]     nxt_beep;
  logic [1:0]        nxt_state;
  logic [1:0]        nxt_mode;
  logic [TIME_W-1:0] nxt_time;
  logic [TIME_W-1:0] base;

`ifdef COOK_ADD30_EN
  logic [TIME_W:0] sum;
  assign sum = {1'b0, time_left} + (TIME_W+1)'(30);
`endif

  always_comb begin
    nxt_state = state;
    nxt_time  = time_left;
    nxt_mode  = led_mode;
    nxt_beep  = beep_cnt;
    base      = time_left;
    case (state)
      IDLE: begin
        if (!door_open && !stop_btn && start_btn &&
            time_load != '0 && mode_sel != 2'b00) begin
          nxt_state = COOK;
          nxt_time  = time_load;
          nxt_mode  = mode_sel;
        end
      end
      COOK: begin
        if (door_open || stop_btn) begin
          nxt_state = PAUSE;
        end else begin
`ifdef COOK_ADD30_EN
          if (start_btn)
            base = sum[TIME_W] ? '1 : sum[TIME_W-1:0];
`endif
          nxt_time = base;
          // add lands first, then the tick decrement
          if (tick) begin
            if (base > TIME_W'(1)) begin
              nxt_time = base - TIME_W'(1);
            end else begin
              nxt_time  = '0;
              nxt_state = DONE;
              nxt_beep  = BEEP_LD;
            end
          end
        end
      end
      PAUSE: begin
        if (stop_btn) begin
          nxt_state = IDLE;
          nxt_time  = '0;
          nxt_mode  = 2'b00;
        end else if (start_btn && !door_open) begin
          nxt_state = COOK;
        end
      end
      default: begin
        if (door_open || stop_btn ||
            (tick && beep_cnt <= BW'(1))) begin
          nxt_state = IDLE;
          nxt_time  = '0;
          nxt_mode  = 2'b00;
        end else if (tick) begin
          nxt_beep = beep_cnt - BW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state     <= IDLE;
      time_left <= '0;
      led_mode  <= 2'b00;
      beep_cnt  <= '0;
      led_en    <= 1'b0;
      led_start <= 1'b0;
      led_idle  <= 1'b1;
      done_beep <= 1'b0;
    end else begin
      state     <= nxt_state;
      time_left <= nxt_time;
      led_mode  <= nxt_mode;
      beep_cnt  <= nxt_beep;
      led_en    <= (nxt_state == COOK);
      led_start <= (nxt_state == COOK);
      led_idle  <= (nxt_state == IDLE);
      done_beep <= (nxt_state == DONE);
    end
  end

endmodule

// File: tb/tb_cook_sequencer.sv
// Self-checking bench for cook_sequencer: stimulus rows with a queued
// expected-output scoreboard, one task per scenario.
module tb_cook_sequencer;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] COOK  = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

`ifdef COOK_ADD30_EN
  localparam logic [7:0] A1 = 8'd255;
  localparam logic [7:0] A2 = 8'd254;
`else
  localparam logic [7:0] A1 = 8'd250;
  localparam logic [7:0] A2 = 8'd249;
`endif

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       door_open = 1'b0;
  logic [1:0] mode_sel = 2'b00;
  logic [7:0] time_load = 8'd0;
  logic       led_en, led_start, led_idle, done_beep;
  logic [1:0] led_mode, state;
  logic [7:0] time_left;

  int cmp = 0;
  int err = 0;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] tl;
    logic [1:0] md;
    logic       en;
    logic       ss;
    logic       id;
    logic       bp;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       st;
    logic       sp;
    logic       dr;
    logic       tk;
    logic [1:0] ms;
    logic [7:0] tl;
    logic [1:0] es;
    logic [7:0] et;
    logic [1:0] em;
  } row_t;

  exp_t exp_q[$];

  cook_sequencer #(.TIME_W(8), .BEEP_TICKS(3)) dut (
    .Clk(Clk), .reset(reset), .tick(tick),
    .start_btn(start_btn), .stop_btn(stop_btn),
    .door_open(door_open), .mode_sel(mode_sel),
    .time_load(time_load), .led_en(led_en),
    .led_start(led_start), .led_idle(led_idle),
    .led_mode(led_mode), .time_left(time_left),
    .done_beep(done_beep), .state(state)
  );

  always #5 Clk = ~Clk;

  function automatic exp_t mk(logic [1:0] s, logic [7:0] t,
                              logic [1:0] m);
    exp_t e;
    e.st = s;
    e.tl = t;
    e.md = m;
    e.en = (s == COOK);
    e.ss = (s == COOK);
    e.id = (s == IDLE);
    e.bp = (s == DONE);
    return e;
  endfunction

  function automatic exp_t snap();
    exp_t g;
    g.st = state;
    g.tl = time_left;
    g.md = led_mode;
    g.en = led_en;
    g.ss = led_start;
    g.id = led_idle;
    g.bp = done_beep;
    return g;
  endfunction

  function automatic row_t r(logic rst, logic st, logic sp,
                             logic dr, logic tk, logic [1:0] ms,
                             logic [7:0] tl, logic [1:0] es,
                             logic [7:0] et, logic [1:0] em);
    row_t x;
    x = '{rst, st, sp, dr, tk, ms, tl, es, et, em};
    return x;
  endfunction

  task automatic apply(input row_t x);
    reset     = x.rst;
    start_btn = x.st;
    stop_btn  = x.sp;
    door_open = x.dr;
    tick      = x.tk;
    mode_sel  = x.ms;
    time_load = x.tl;
    @(posedge Clk);
    #1;
    reset     = 1'b0;
    start_btn = 1'b0;
    stop_btn  = 1'b0;
    tick      = 1'b0;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e, g;
    rows.push_back(r(1,0,0,0,0,0,0,  IDLE,0,0));
    rows.push_back(r(0,0,0,0,1,1,5,  IDLE,0,0));
    rows.push_back(r(0,0,1,0,0,1,5,  IDLE,0,0));
    foreach (rows[i]) begin
      exp_q.push_back(mk(rows[i].es, rows[i].et, rows[i].em));
      apply(rows[i]);
      g = snap(); e = exp_q.pop_front(); cmp++;
      if (g !== e) begin
        err++;
        $display("FAIL reset[%0d] got=%h required=%h", i, g, e);
      end
    end
  endtask

  task automatic test_normal_cook();
    row_t rows[$];
    exp_t e, g;
    rows.push_back(r(0,1,0,0,0,1,3,  COOK,3,1));
    rows.push_back(r(0,0,0,0,1,1,3,  COOK,2,1));
    rows.push_back(r(0,0,0,0,0,1,3,  COOK,2,1));
    rows.push_back(r(0,0,0,0,1,1,3,  COOK,1,1));
    rows.push_back(r(0,0,0,0,1,1,3,  DONE,0,1));
    rows.push_back(r(0,0,0,0,1,1,3,  DONE,0,1));
    rows.push_back(r(0,0,0,0,0,1,3,  DONE,0,1));
    rows.push_back(r(0,0,0,0,1,1,3,  DONE,0,1));
    rows.push_back(r(0,0,0,0,1,1,3,  IDLE,0,0));
    foreach (rows[i]) begin
      exp_q.push_back(mk(rows[i].es, rows[i].et, rows[i].em));
      apply(rows[i]);
      g = snap(); e = exp_q.pop_front(); cmp++;
      if (g !== e) begin
        err++;
        $display("FAIL normal[%0d] got=%h required=%h", i, g, e);
      end
    end
  endtask

  task automatic test_pause_resume();
    row_t rows[$];
    exp_t e, g;
    rows.push_back(r(0,1,0,0,0,2,5,  COOK,5,2));
    rows.push_back(r(0,0,0,0,1,2,5,  COOK,4,2));
    rows.push_back(r(0,0,0,0,1,2,5,  COOK,3,2));
    rows.push_back(r(0,0,0,1,0,2,5,  PAUSE,3,2));
    rows.push_back(r(0,0,0,1,1,2,5,  PAUSE,3,2));
    rows.push_back(r(0,1,0,1,0,2,5,  PAUSE,3,2));
    rows.push_back(r(0,0,0,0,1,2,5,  PAUSE,3,2));
    rows.push_back(r(0,1,0,0,0,2,5,  COOK,3,2));
    rows.push_back(r(0,0,0,0,1,2,5,  COOK,2,2));
    foreach (rows[i]) begin
      exp_q.push_back(mk(rows[i].es, rows[i].et, rows[i].em));
      apply(rows[i]);
      g = snap(); e = exp_q.pop_front(); cmp++;
      if (g !== e) begin
        err++;
        $display("FAIL pause[%0d] got=%h required=%h", i, g, e);
      end
    end
  endtask

  task automatic test_cancel();
    row_t rows[$];
    exp_t e, g;
    rows.push_back(r(0,0,0,1,0,2,5,  PAUSE,2,2));
    rows.push_back(r(0,0,1,0,0,2,5,  IDLE,0,0));
    foreach (rows[i]) begin
      exp_q.push_back(mk(rows[i].es, rows[i].et, rows[i].em));
      apply(rows[i]);
      g = snap(); e = exp_q.pop_front(); cmp++;
      if (g !== e) begin
        err++;
        $display("FAIL cancel[%0d] got=%h required=%h", i, g, e);
      end
    end
  endtask

  task automatic test_rejections();
    row_t rows[$];
    exp_t e, g;
    rows.push_back(r(0,1,0,0,0,1,0,  IDLE,0,0));
    rows.push_back(r(0,1,0,0,0,0,5,  IDLE,0,0));
    rows.push_back(r(0,1,0,1,0,1,5,  IDLE,0,0));
    rows.push_back(r(0,1,1,0,0,1,5,  IDLE,0,0));
    foreach (rows[i]) begin
      exp_q.push_back(mk(rows[i].es, rows[i].et, rows[i].em));
      apply(rows[i]);
      g = snap(); e = exp_q.pop_front(); cmp++;
      if (g !== e) begin
        err++;
        $display("FAIL reject[%0d] got=%h required=%h", i, g, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    row_t rows[$];
    exp_t e, g;
    rows.push_back(r(0,1,0,0,0,3,4,  COOK,4,3));
    rows.push_back(r(0,0,1,0,1,3,4,  PAUSE,4,3));
    rows.push_back(r(0,1,0,0,0,3,4,  COOK,4,3));
    rows.push_back(r(0,1,1,0,0,3,4,  PAUSE,4,3));
    rows.push_back(r(0,1,0,0,0,3,4,  COOK,4,3));
    rows.push_back(r(1,1,0,0,1,3,4,  IDLE,0,0));
    foreach (rows[i]) begin
      exp_q.push_back(mk(rows[i].es, rows[i].et, rows[i].em));
      apply(rows[i]);
      g = snap(); e = exp_q.pop_front(); cmp++;
      if (g !== e) begin
        err++;
        $display("FAIL simul[%0d] got=%h required=%h", i, g, e);
      end
    end
  endtask

  task automatic test_add30();
    row_t rows[$];
    exp_t e, g;
    rows.push_back(r(0,1,0,0,0,1,250, COOK,250,1));
    rows.push_back(r(0,1,0,0,0,1,250, COOK,A1,1));
    rows.push_back(r(0,1,0,0,1,1,250, COOK,A2,1));
    rows.push_back(r(0,0,1,0,0,1,250, PAUSE,A2,1));
    rows.push_back(r(0,0,1,0,0,1,250, IDLE,0,0));
    foreach (rows[i]) begin
      exp_q.push_back(mk(rows[i].es, rows[i].et, rows[i].em));
      apply(rows[i]);
      g = snap(); e = exp_q.pop_front(); cmp++;
      if (g !== e) begin
        err++;
        $display("FAIL add30[%0d] got=%h required=%h", i, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e, g;
    rows.push_back(r(0,1,0,0,0,2,1,  COOK,1,2));
    rows.push_back(r(0,0,0,0,1,2,1,  DONE,0,2));
    rows.push_back(r(0,0,0,1,0,2,1,  IDLE,0,0));
    rows.push_back(r(0,1,0,0,0,3,2,  COOK,2,3));
    rows.push_back(r(0,0,0,0,1,3,2,  COOK,1,3));
    rows.push_back(r(0,0,0,0,1,3,2,  DONE,0,3));
    rows.push_back(r(0,0,1,0,1,3,2,  IDLE,0,0));
    foreach (rows[i]) begin
      exp_q.push_back(mk(rows[i].es, rows[i].et, rows[i].em));
      apply(rows[i]);
      g = snap(); e = exp_q.pop_front(); cmp++;
      if (g !== e) begin
        err++;
        $display("FAIL b2b[%0d] got=%h required=%h", i, g, e);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_normal_cook();
    test_pause_resume();
    test_cancel();
    test_rejections();
    test_simultaneous();
    test_add30();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
